// File: rtl/multi_blink.sv
// N-channel LED pattern generator: shared tick prescaler, per-channel OFF/ON/BLINK/BURST FSMs.
// Config writes land on the next edge and show on led the cycle after; cfg_ready is high whenever out of reset.
module multi_blink #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int CH      = 4,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8,
  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_mode,
  input  logic [CNT_W-1:0]   cfg_on,
  input  logic [CNT_W-1:0]   cfg_off,
  input  logic [BURST_W-1:0] cfg_count,
  output logic [CH-1:0]      led,
  output logic [CH-1:0]      busy,
  output logic [CH-1:0]      done,
  output logic               tick
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_PH_ON, S_PH_OFF} state_t;

  generate
    if (DIV < 2) begin : g_div_chk
      $error("multi_blink: CLK_HZ/TICK_HZ must be at least 2");
    end
  endgenerate

  logic [PRE_W-1:0] r_pre;
  logic             r_tick;
  logic             r_ready;

  // r_tick is registered one count early so it is high exactly while r_pre == DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre   <= '0;
      r_tick  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_tick  <= (r_pre == PRE_W'(DIV - 2));
      r_pre   <= (r_pre == PRE_W'(DIV - 1)) ? '0 : r_pre + PRE_W'(1);
    end
  end

  assign tick      = r_tick;
  assign cfg_ready = r_ready;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_t             r_state, w_state_nxt;
    logic [1:0]         r_mode;
    logic [CNT_W-1:0]   r_on, r_off, r_ph, w_ph_nxt, w_ph_inc, w_on_len, w_off_len;
    logic [BURST_W-1:0] r_count, r_pulse, w_pulse_nxt, w_pulse_inc;
    logic               r_led, r_busy, r_done;
    logic               w_led_nxt, w_busy_nxt, w_done_nxt, w_wr;

    assign w_wr        = cfg_valid && r_ready && (cfg_ch == CH_W'(g));
    assign w_on_len    = (r_on == '0) ? CNT_W'(1) : r_on;
    assign w_off_len   = (r_off == '0) ? CNT_W'(1) : r_off;
    assign w_ph_inc    = r_ph + CNT_W'(1);
    assign w_pulse_inc = r_pulse + BURST_W'(1);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_mode  <= MODE_OFF;
        r_on    <= '0;
        r_off   <= '0;
        r_count <= '0;
        r_ph    <= '0;
        r_pulse <= '0;
        r_led   <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_ph    <= w_ph_nxt;
        r_pulse <= w_pulse_nxt;
        r_led   <= w_led_nxt;
        r_busy  <= w_busy_nxt;
        r_done  <= w_done_nxt;
        if (w_wr) begin
          r_mode  <= cfg_mode;
          r_on    <= cfg_on;
          r_off   <= cfg_off;
          r_count <= cfg_count;
        end
      end
    end

    // A write overrides everything, including a burst completing on the same tick.
    always_comb begin
      w_state_nxt = r_state;
      w_ph_nxt    = r_ph;
      w_pulse_nxt = r_pulse;
      w_led_nxt   = 1'b0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      if (w_wr) begin
        w_ph_nxt    = '0;
        w_pulse_nxt = '0;
        case (cfg_mode)
          MODE_ON: begin
            w_state_nxt = S_IDLE;
            w_led_nxt   = 1'b1;
          end
          MODE_BLINK: begin
            w_state_nxt = S_PH_ON;
            w_led_nxt   = 1'b1;
          end
          MODE_BURST: begin
            if (cfg_count == '0) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_PH_ON;
              w_led_nxt   = 1'b1;
              w_busy_nxt  = 1'b1;
            end
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end else begin
        case (r_state)
          S_PH_ON: begin
            w_led_nxt  = 1'b1;
            w_busy_nxt = (r_mode == MODE_BURST);
            if (r_tick) begin
              if (w_ph_inc == w_on_len) begin
                w_ph_nxt  = '0;
                w_led_nxt = 1'b0;
                if (r_mode == MODE_BURST && w_pulse_inc == r_count) begin
                  w_state_nxt = S_IDLE;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_pulse_nxt = '0;
                end else begin
                  w_state_nxt = S_PH_OFF;
                  if (r_mode == MODE_BURST) w_pulse_nxt = w_pulse_inc;
                end
              end else begin
                w_ph_nxt = w_ph_inc;
              end
            end
          end
          S_PH_OFF: begin
            w_busy_nxt = (r_mode == MODE_BURST);
            if (r_tick) begin
              if (w_ph_inc == w_off_len) begin
                w_ph_nxt    = '0;
                w_state_nxt = S_PH_ON;
                w_led_nxt   = 1'b1;
              end else begin
                w_ph_nxt = w_ph_inc;
              end
            end
          end
          default: w_led_nxt = (r_mode == MODE_ON);
        endcase
      end
    end

    assign led[g]  = r_led;
    assign busy[g] = r_busy;
    assign done[g] = r_done;
  end

endmodule
